lfsr_checker: RTL and testbench



---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_checker.sv | 138 +++++++++++++
 tb/tb_lfsr_checker.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 10-bit XNOR LFSR generator and its receive-side checker.
package lfsr_pkg;

    localparam int LFSR_BITS = 10;
    localparam int TAP_HI    = 10;
    localparam int TAP_LO    = 7;

    typedef enum logic [1:0] {
        FILL,
        VERIFY,
        LOCKED
    } chk_state_t;

    // Next bit shifted into Q[1]; the &Q[9:1] term breaks the all-ones lockup.
    function automatic logic lfsr_next_bit(input logic [LFSR_BITS:1] s);
        return ~(s[TAP_HI] ^ s[TAP_LO] ^ (&s[LFSR_BITS-1:1]));
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 10-bit XNOR LFSR stream: fills a shadow
// register, verifies predictions until confident, then flywheels and counts errors.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned MATCH_NEED  = 16,
    parameter int unsigned WINDOW      = 32,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int MATCH_W = $clog2(MATCH_NEED + 1);
    localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    chk_state_t             state_q, state_d;
    logic [LFSR_BITS:1]     shadow_q, shadow_d;
    logic [3:0]             fill_cnt_q, fill_cnt_d;
    logic [MATCH_W-1:0]     match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]      win_err_q, win_err_d;
    logic                   err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]       err_count_q, err_count_d;

    logic                   exp_bit;
    logic                   mismatch;
    logic                   count_err;
    logic [MATCH_W-1:0]     match_inc;
    logic [WERR_W-1:0]      win_err_inc;

    // Next-state: FSM transitions, shadow register update and all counters.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        count_err   = 1'b0;

        exp_bit     = lfsr_next_bit(shadow_q);
        mismatch    = (in_bit != exp_bit);
        match_inc   = match_cnt_q + MATCH_W'(1);
        win_err_inc = win_err_q + WERR_W'(mismatch);

        if (in_valid) begin
            case (state_q)
                FILL: begin
                    shadow_d = {shadow_q[LFSR_BITS-1:1], in_bit};
                    if (fill_cnt_q == 4'(LFSR_BITS - 1)) begin
                        state_d     = VERIFY;
                        fill_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 4'd1;
                    end
                end
                VERIFY: begin
                    // Realign to the received stream until enough predictions hold.
                    shadow_d = {shadow_q[LFSR_BITS-1:1], in_bit};
                    if (mismatch) begin
                        match_cnt_d = '0;
                    end else if (match_inc == MATCH_W'(MATCH_NEED)) begin
                        state_d     = LOCKED;
                        match_cnt_d = '0;
                        win_cnt_d   = '0;
                        win_err_d   = '0;
                    end else begin
                        match_cnt_d = match_inc;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so a corrupted bit cannot poison the shadow.
                    shadow_d    = {shadow_q[LFSR_BITS-1:1], exp_bit};
                    count_err   = mismatch;
                    err_pulse_d = mismatch;
                    if (win_err_inc == WERR_W'(LOSS_THRESH)) begin
                        state_d     = VERIFY;
                        match_cnt_d = '0;
                    end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_err_d = win_err_inc;
                    end
                end
                default: state_d = FILL;
            endcase
        end

        // Clear wins over the count, but an error in the same cycle still registers.
        if (err_clr) begin
            err_count_d = count_err ? ERR_W'(1) : '0;
        end else if (count_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= FILL;
            shadow_q    <= '0;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a default instance and an ERR_W=4 instance share stimulus.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked_sat, pulse_sat;
    logic [3:0]  err_count_sat;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          pulse_seen = 0;
    logic [10:1] gen = '0;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    lfsr_checker #(.ERR_W(4)) dut_sat (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .err_clr   (err_clr),
        .locked    (locked_sat),
        .err_pulse (pulse_sat),
        .err_count (err_count_sat)
    );

    // One clock with the given inputs; outputs are stable #1 after the edge.
    task automatic step(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        err_clr  = 1'b0;
        if (err_pulse === 1'b1) pulse_seen++;
    endtask

    // Advance the reference generator and send its bit, optionally inverted.
    task automatic golden(input logic inv);
        logic nb;
        nb  = ~(gen[10] ^ gen[7] ^ (&gen[9:1]));
        gen = {gen[9:1], nb};
        step(1'b1, nb ^ inv);
    endtask

    task automatic golden_n(input int n);
        repeat (n) golden(1'b0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(1'b0, 1'b0);
        Reset = 1'b0;
        gen = '0;
        pulse_seen = 0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(1'b1, 1'b1);
        Reset = 1'b0;
        gen = '0;
        pulse_seen = 0;
        n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
        n_checks++; if (err_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", err_pulse); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", err_count); else n_pass++;
        n_checks++; if (err_count_sat !== 4'd0) $display("FAIL reset_count_sat: got %0d want 0", err_count_sat); else n_pass++;
    endtask

    task automatic test_lock();
        do_reset();
        golden_n(25);
        n_checks++; if (locked !== 1'b0) $display("FAIL lock_early: got %b want 0 after 25 bits", locked); else n_pass++;
        golden(1'b0);
        n_checks++; if (locked !== 1'b1) $display("FAIL lock_rise: got %b want 1 after 26 bits", locked); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL lock_count: got %0d want 0", err_count); else n_pass++;
        n_checks++; if (pulse_seen !== 0) $display("FAIL lock_pulses: got %0d want 0", pulse_seen); else n_pass++;
    endtask

    task automatic test_single_error();
        golden(1'b1);
        n_checks++; if (err_pulse !== 1'b1) $display("FAIL single_pulse: got %b want 1", err_pulse); else n_pass++;
        n_checks++; if (err_count !== 16'd1) $display("FAIL single_count: got %0d want 1", err_count); else n_pass++;
        n_checks++; if (locked !== 1'b1) $display("FAIL single_locked: got %b want 1", locked); else n_pass++;
        golden(1'b0);
        n_checks++; if (err_pulse !== 1'b0) $display("FAIL single_pulse_drop: got %b want 0", err_pulse); else n_pass++;
        pulse_seen = 0;
        golden_n(40);
        n_checks++; if (pulse_seen !== 0) $display("FAIL flywheel_pulses: got %0d want 0", pulse_seen); else n_pass++;
        n_checks++; if (err_count !== 16'd1) $display("FAIL flywheel_count: got %0d want 1", err_count); else n_pass++;
        n_checks++; if (locked !== 1'b1) $display("FAIL flywheel_locked: got %b want 1", locked); else n_pass++;
    endtask

    task automatic test_loss_relock();
        do_reset();
        golden_n(26);
        golden(1'b1); golden_n(4);
        golden(1'b1); golden_n(4);
        golden(1'b1); golden_n(4);
        n_checks++; if (locked !== 1'b1) $display("FAIL loss_before: got %b want 1 after 3 errors", locked); else n_pass++;
        golden(1'b1);
        n_checks++; if (locked !== 1'b0) $display("FAIL loss_fall: got %b want 0 after 4th error", locked); else n_pass++;
        n_checks++; if (err_count !== 16'd4) $display("FAIL loss_count: got %0d want 4", err_count); else n_pass++;
        golden_n(15);
        n_checks++; if (locked !== 1'b0) $display("FAIL relock_early: got %b want 0 after 15 matches", locked); else n_pass++;
        golden(1'b0);
        n_checks++; if (locked !== 1'b1) $display("FAIL relock_rise: got %b want 1 after 16 matches", locked); else n_pass++;
        n_checks++; if (err_count !== 16'd4) $display("FAIL relock_count: got %0d want 4", err_count); else n_pass++;
    endtask

    // Errors at window indices 5, 20, 31 then 32: the last falls in the next window.
    task automatic test_window();
        do_reset();
        golden_n(26);
        golden_n(5);  golden(1'b1);
        golden_n(14); golden(1'b1);
        golden_n(10); golden(1'b1);
        n_checks++; if (locked !== 1'b1) $display("FAIL window_end: got %b want 1", locked); else n_pass++;
        golden(1'b1);
        n_checks++; if (locked !== 1'b1) $display("FAIL window_next: got %b want 1", locked); else n_pass++;
        golden_n(8);
        n_checks++; if (locked !== 1'b1) $display("FAIL window_hold: got %b want 1", locked); else n_pass++;
        n_checks++; if (err_count !== 16'd4) $display("FAIL window_count: got %0d want 4", err_count); else n_pass++;
    endtask

    task automatic test_idle_gaps();
        int          idle_bad;
        logic        lk;
        logic [15:0] ec;
        do_reset();
        idle_bad = 0;
        for (int i = 0; i < 30; i++) begin
            golden(1'b0);
            if (i == 24) begin
                n_checks++; if (locked !== 1'b0) $display("FAIL idle_early: got %b want 0 after 25 bits", locked); else n_pass++;
            end
            if (i == 25) begin
                n_checks++; if (locked !== 1'b1) $display("FAIL idle_lock: got %b want 1 after 26 bits", locked); else n_pass++;
            end
            repeat ($urandom_range(1, 5)) begin
                lk = locked;
                ec = err_count;
                step(1'b0, 1'($urandom));
                if (locked !== lk || err_pulse !== 1'b0 || err_count !== ec) idle_bad++;
            end
        end
        n_checks++; if (idle_bad !== 0) $display("FAIL idle_hold: got %0d disturbed idle cycles want 0", idle_bad); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL idle_count: got %0d want 0", err_count); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        golden_n(26);
        repeat (5) begin
            repeat (4) golden(1'b1);
            golden_n(16);
        end
        n_checks++; if (err_count_sat !== 4'd15) $display("FAIL sat_count: got %0d want 15", err_count_sat); else n_pass++;
        n_checks++; if (err_count !== 16'd20) $display("FAIL wide_count: got %0d want 20", err_count); else n_pass++;
        n_checks++; if (locked_sat !== 1'b1) $display("FAIL sat_locked: got %b want 1", locked_sat); else n_pass++;
        err_clr = 1'b1;
        golden(1'b1);
        n_checks++; if (err_count_sat !== 4'd1) $display("FAIL clr_err_sat: got %0d want 1", err_count_sat); else n_pass++;
        n_checks++; if (err_count !== 16'd1) $display("FAIL clr_err: got %0d want 1", err_count); else n_pass++;
        n_checks++; if (pulse_sat !== 1'b1) $display("FAIL clr_pulse: got %b want 1", pulse_sat); else n_pass++;
        err_clr = 1'b1;
        golden(1'b0);
        n_checks++; if (err_count !== 16'd0) $display("FAIL clr_plain: got %0d want 0", err_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        golden(1'b1);
        n_checks++; if (locked !== 1'b1) $display("FAIL mid_pre: got %b want 1", locked); else n_pass++;
        Reset = 1'b1;
        step(1'b1, 1'b0);
        Reset = 1'b0;
        gen = '0;
        n_checks++; if (locked !== 1'b0) $display("FAIL mid_locked: got %b want 0", locked); else n_pass++;
        n_checks++; if (err_pulse !== 1'b0) $display("FAIL mid_pulse: got %b want 0", err_pulse); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL mid_count: got %0d want 0", err_count); else n_pass++;
        n_checks++; if (err_count_sat !== 4'd0) $display("FAIL mid_count_sat: got %0d want 0", err_count_sat); else n_pass++;
        golden_n(25);
        n_checks++; if (locked !== 1'b0) $display("FAIL mid_refill: got %b want 0 after 25 bits", locked); else n_pass++;
        golden(1'b0);
        n_checks++; if (locked !== 1'b1) $display("FAIL mid_relock: got %b want 1 after 26 bits", locked); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_window();
        test_idle_gaps();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
